// File: rtl/uart_pkg.sv
// Shared types and line constants for the UART transmit frame controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP1,
    STOP2
  } tx_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/uart_tx_shadow_reg.sv
// Per-frame shadow of the accepted word and its configuration. The parity
// bit is computed from the incoming word and registered at acceptance.
module uart_tx_shadow_reg
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_en,
  input  logic                  i_par_typ,
  input  logic                  i_stop2,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_par_en,
  output logic                  o_stop2,
  output logic                  o_par_bit
);

  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_stop2;
  logic                  r_par_bit;
  logic                  w_par_bit;

  assign w_par_bit = (i_par_typ == PAR_ODD) ? ~^i_data : ^i_data;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_stop2   <= 1'b0;
      r_par_bit <= 1'b0;
    end else if (i_load) begin
      r_data    <= i_data;
      r_par_en  <= i_par_en;
      r_stop2   <= i_stop2;
      r_par_bit <= w_par_bit;
    end
  end

  assign o_data    = r_data;
  assign o_par_en  = r_par_en;
  assign o_stop2   = r_stop2;
  assign o_par_bit = r_par_bit;

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: pulls words from the FIFO read side and
// serialises start/data/parity/stop bits, one bit per CLK cycle.
module uart_tx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  RD_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(DATA_WIDTH - 1);

  // Handshake: a word is taken on any edge where DATA_VALID=1 and the FSM is
  // idle or in its final stop cycle; RD_INC pulses during the following
  // START cycle so the FIFO advances exactly once per frame.
  tx_state_t             r_state;
  tx_state_t             w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_idx;
  logic [CNT_WIDTH-1:0]  w_idx_nxt;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_rd_inc;
  logic                  w_accept;
  logic                  w_tx_nxt;

  logic [DATA_WIDTH-1:0] w_sh_data;
  logic                  w_sh_par_en;
  logic                  w_sh_stop2;
  logic                  w_sh_par_bit;

  uart_tx_shadow_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shadow (
    .i_clk    (CLK),
    .i_rst_n  (RST),
    .i_load   (w_accept),
    .i_data   (P_DATA),
    .i_par_en (PAR_EN),
    .i_par_typ(PAR_TYP),
    .i_stop2  (STOP2),
    .o_data   (w_sh_data),
    .o_par_en (w_sh_par_en),
    .o_stop2  (w_sh_stop2),
    .o_par_bit(w_sh_par_bit)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (DATA_VALID) w_accept = 1'b1;
      end
      START: begin
        w_state_nxt = DATA;
        w_idx_nxt   = '0;
      end
      DATA: begin
        if (r_idx == LAST_IDX) w_state_nxt = w_sh_par_en ? PARITY : STOP1;
        else                   w_idx_nxt   = r_idx + 1'b1;
      end
      PARITY: w_state_nxt = STOP1;
      STOP1: begin
        if (w_sh_stop2)      w_state_nxt = uart_pkg::STOP2;
        else if (DATA_VALID) w_accept    = 1'b1;
        else                 w_state_nxt = IDLE;
      end
      uart_pkg::STOP2: begin
        if (DATA_VALID) w_accept    = 1'b1;
        else            w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_accept) w_state_nxt = START;

    // Line level is derived from the state being entered so it can be registered.
    w_tx_nxt = LINE_IDLE;
    case (w_state_nxt)
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = w_sh_data[w_idx_nxt];
      PARITY:  w_tx_nxt = w_sh_par_bit;
      default: w_tx_nxt = LINE_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_tx     <= LINE_IDLE;
      r_busy   <= 1'b0;
      r_rd_inc <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_tx     <= w_tx_nxt;
      r_busy   <= (w_state_nxt != IDLE);
      r_rd_inc <= w_accept;
    end
  end

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;
  assign RD_INC = r_rd_inc;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed and randomised bench for uart_tx_frame_ctrl against a frame-level
// model that expands each queued word into its expected per-cycle line trace.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic [DW-1:0] P_DATA = '0;
  logic          DATA_VALID = 1'b0;
  logic          PAR_EN = 1'b0;
  logic          PAR_TYP = 1'b0;
  logic          STOP2 = 1'b0;
  logic          RD_INC;
  logic          TX_OUT;
  logic          BUSY;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          par_en;
    logic          par_typ;
    logic          stop2;
  } word_t;

  word_t      stim_q[$];
  logic [2:0] exp_q[$];  // {rd_inc, busy, tx} per cycle
  int         n_checks = 0;
  int         n_fail   = 0;
  word_t      w;

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .STOP2     (STOP2),
    .RD_INC    (RD_INC),
    .TX_OUT    (TX_OUT),
    .BUSY      (BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic word_t mk(input logic [DW-1:0] d, input logic pe,
                               input logic pt, input logic s2);
    word_t r;
    r.data = d; r.par_en = pe; r.par_typ = pt; r.stop2 = s2;
    return r;
  endfunction

  // Frame model: start, LSB-first data, optional parity, one or two stops.
  task automatic add_frame(input word_t f);
    logic pbit;
    exp_q.push_back(3'b110);
    for (int i = 0; i < DW; i++) exp_q.push_back({2'b01, f.data[i]});
    if (f.par_en) begin
      pbit = 1'($countones(f.data) % 2) ^ f.par_typ;
      exp_q.push_back({2'b01, pbit});
    end
    exp_q.push_back(3'b011);
    if (f.stop2) exp_q.push_back(3'b011);
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b001);
  endtask

  task automatic queue_word(input word_t f);
    stim_q.push_back(f);
    add_frame(f);
  endtask

  // Behaves like the FIFO read side: head word shown while non-empty.
  task automatic drive_inputs();
    if (stim_q.size() > 0) begin
      DATA_VALID = 1'b1;
      P_DATA     = stim_q[0].data;
      PAR_EN     = stim_q[0].par_en;
      PAR_TYP    = stim_q[0].par_typ;
      STOP2      = stim_q[0].stop2;
    end else begin
      DATA_VALID = 1'b0;
      P_DATA     = DW'($urandom);
      PAR_EN     = 1'($urandom);
      PAR_TYP    = 1'($urandom);
      STOP2      = 1'($urandom);
    end
  endtask

  task automatic step();
    logic [2:0] e;
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check("tx_out", TX_OUT, e[0]);
    check("busy", BUSY, e[1]);
    check("rd_inc", RD_INC, e[2]);
    if (RD_INC && stim_q.size() > 0) void'(stim_q.pop_front());
    drive_inputs();
  endtask

  task automatic run();
    drive_inputs();
    while (exp_q.size() > 0) step();
  endtask

  task automatic check_reset_vals(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK);
      #1;
      check("rst_tx_out", TX_OUT, 1'b1);
      check("rst_busy", BUSY, 1'b0);
      check("rst_rd_inc", RD_INC, 1'b0);
    end
  endtask

  initial begin
    // Reset held with a word pending, then 0xA5 plain frame after release.
    RST = 1'b0;
    w = mk(8'hA5, 1'b0, 1'b0, 1'b0);
    stim_q.push_back(w);
    drive_inputs();
    check_reset_vals(4);
    RST = 1'b1;
    add_frame(w);
    add_idle(3);
    run();

    // Even and odd parity on 0xA5, then parity with two stop bits.
    queue_word(mk(8'hA5, 1'b1, 1'b0, 1'b0)); add_idle(2); run();
    queue_word(mk(8'hA5, 1'b1, 1'b1, 1'b0)); add_idle(2); run();
    queue_word(mk(8'hA5, 1'b1, 1'b0, 1'b1)); add_idle(2); run();

    // Back-to-back words with no idle gap.
    queue_word(mk(8'h01, 1'b0, 1'b0, 1'b0));
    queue_word(mk(8'h80, 1'b0, 1'b0, 1'b0));
    add_idle(2);
    run();

    // Config changes after acceptance must not alter the frame in flight.
    w = mk(8'h3C, 1'b1, 1'b1, 1'b0);
    queue_word(w);
    add_idle(2);
    drive_inputs();
    step();
    PAR_EN  = 1'b0;
    PAR_TYP = ~w.par_typ;
    STOP2   = 1'b1;
    while (exp_q.size() > 0) begin
      step();
      PAR_EN = 1'b0;
    end

    // Reset mid-DATA: line high and BUSY low at once, no later RD_INC.
    queue_word(mk(8'hA5, 1'b1, 1'b0, 1'b0));
    drive_inputs();
    for (int i = 0; i < 5; i++) step();
    RST = 1'b0;
    #1;
    check("async_tx_out", TX_OUT, 1'b1);
    check("async_busy", BUSY, 1'b0);
    check("async_rd_inc", RD_INC, 1'b0);
    exp_q.delete();
    stim_q.delete();
    drive_inputs();
    check_reset_vals(3);
    RST = 1'b1;
    add_idle(4);
    run();

    // Randomised batches of words with per-frame configuration.
    for (int b = 0; b < 8; b++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        queue_word(mk(DW'($urandom), 1'($urandom), 1'($urandom), 1'($urandom)));
      add_idle($urandom_range(1, 3));
      run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame_ctrl.md
Name: uart_tx_frame_ctrl

Overview:
Parametrised successor to the UART transmit path in the multi-clock system. It combines the serializer with the FIFO read handshake, so no separate PULSE_GEN is needed. It runs in the TX clock domain, where one CLK cycle equals one bit time. It pulls words directly from the async FIFO read side and generates the read-increment pulse itself. New capabilities:
- configurable data width
- optional second stop bit
- per-frame latched configuration
- gap-free back-to-back frames

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..16), sent LSB first
CNT_WIDTH, $clog2(DATA_WIDTH), width of the bit-index counter (derived; do not override)

Ports:
CLK  input  1  TX bit clock (divided UART clock)
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  FIFO RD_DATA word
DATA_VALID  input  1  word available (driven from ~EMPTY of FIFO)
PAR_EN  input  1  1 = append parity bit
PAR_TYP  input  1  0 = even, 1 = odd
STOP2  input  1  1 = two stop bits, 0 = one
RD_INC  output  1  one-cycle FIFO read-increment pulse
TX_OUT  output  1  serial line, idle high
BUSY  output  1  high for every cycle a frame bit is on the line

Behaviour:
- Reset (RST=0, asynchronous): state=IDLE, TX_OUT=1, BUSY=0, RD_INC=0, all internal registers cleared. Release takes effect on the next CLK edge.
- All outputs are registered; no combinational path from inputs to outputs.
- States: IDLE, START, DATA, PARITY, STOP1, STOP2.
- Acceptance: on a CLK edge with state=IDLE or STOP_LAST and DATA_VALID=1:
  - latch P_DATA, PAR_EN, PAR_TYP, STOP2 into shadow registers;
  - next state = START;
  - RD_INC=1 for exactly that next cycle.
  - Config changes after acceptance do not affect the frame in flight.
- STOP_LAST means STOP1 when shadow STOP2=0, otherwise the STOP2 state.
- Per-state line and transitions:
  - START: TX_OUT=0, 1 cycle -> DATA with bit index 0.
  - DATA: TX_OUT=data[idx], idx increments each cycle. After idx=DATA_WIDTH-1 -> PARITY if shadow PAR_EN, else STOP1.
  - PARITY: TX_OUT = ^data when even, ~^data when odd; 1 cycle -> STOP1.
  - STOP1: TX_OUT=1. Next state is STOP2 if shadow STOP2; else START if DATA_VALID (back-to-back); else IDLE.
  - STOP2: TX_OUT=1. Next state is START if DATA_VALID, else IDLE.
- Frame length is 2 + DATA_WIDTH + PAR_EN + STOP2 cycles, with no idle gap between back-to-back frames.
- BUSY=1 in START/DATA/PARITY/STOP1/STOP2 and 0 in IDLE. It stays 1 continuously across back-to-back frames.
- Exactly one RD_INC pulse per frame; RD_INC never asserts outside the START cycle.
- DATA_VALID is ignored in START/DATA/PARITY and in non-final stop cycles. No word loss occurs because the FIFO holds it.
- DATA_VALID dropping mid-frame has no effect on the frame in flight.
- Reset asserted mid-frame: line returns high immediately and the partial frame is abandoned. No RD_INC is issued afterwards.
- Bit-index counter saturation is not reachable; it is reset to 0 on every START.

Decomposition:
- Shared package uart_pkg holds:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP1, STOP2};
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1;
  - constants LINE_IDLE=1'b1, START_BIT=1'b0.
- One natural sub-module: uart_tx_shadow_reg. It holds the acceptance latch of data and config plus the parity precompute; the parity result is registered at acceptance.
- The FSM and bit counter stay in the top-level block.

Test Plan:
1. Reset held, DATA_VALID=1 -> TX_OUT=1, BUSY=0, RD_INC=0 throughout. After release, START begins on the first edge.
2. DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=0, STOP2=0 -> line 0,1,0,1,0,0,1,0,1,1 (10 cycles). RD_INC high only in cycle 1. BUSY high for 10 cycles, then 0.
3. P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> parity bit 0. With PAR_TYP=1 -> parity bit 1. Frame is 11 cycles.
4. STOP2=1, PAR_EN=1 -> 12-cycle frame, with TX_OUT=1 in the last two cycles.
5. DATA_VALID held high with words 0x01 then 0x80 -> second START immediately follows the stop bit with no idle cycle. BUSY stays high. Exactly 2 RD_INC pulses, 10 cycles apart.
6. Toggle PAR_EN 1->0 and assert RST low mid-DATA of a PAR_EN=1 frame:
   - PAR_EN toggle: the frame still carries parity.
   - RST assertion: TX_OUT=1 and BUSY=0 asynchronously; no further RD_INC.
